// File: rtl/memory_responder.sv
// Single-port 8-bit memory slave with a fixed WAIT-cycle access latency.
// Requests are latched in IDLE, the access happens WAIT edges later, and a one-cycle RESP follows.
module memory_responder #(
    parameter int WAIT  = 2,
    parameter int DEPTH = 8192
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MEM_read,
    input  logic        MEM_write,
    input  logic [12:0] addr,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        ready,
    output logic        busy,
    output logic        err
);
    localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [13:0] DEPTH_W   = 14'(DEPTH);
    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t        state_reg;
    logic [3:0]    cnt_reg;
    logic [12:0]   addr_reg;
    logic [7:0]    wdata_reg;
    logic          op_write_reg;
    logic [7:0]    mem [DEPTH];

    logic          in_range;
    logic          access_now;
    logic          mem_we;
    logic [AW-1:0] mem_idx;

    // Range is judged on the latched address, so late addr changes cannot affect it.
    assign in_range   = ({1'b0, addr_reg} < DEPTH_W);
    assign access_now = (state_reg == BUSY) && (cnt_reg == 4'd0);
    assign mem_we     = access_now && op_write_reg && in_range;
    assign mem_idx    = addr_reg[AW-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            cnt_reg      <= 4'd0;
            addr_reg     <= 13'd0;
            wdata_reg    <= 8'd0;
            op_write_reg <= 1'b0;
            rdata        <= 8'h00;
            ready        <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (MEM_read ^ MEM_write) begin
                        addr_reg     <= addr;
                        wdata_reg    <= wdata;
                        op_write_reg <= MEM_write;
                        cnt_reg      <= WAIT_LOAD;
                        busy         <= 1'b1;
                        state_reg    <= BUSY;
                    end else if (MEM_read && MEM_write) begin
                        err <= 1'b1;
                    end
                end
                BUSY: begin
                    if (cnt_reg == 4'd0) begin
                        // Out-of-range accesses of either kind report zero data.
                        if (!in_range) begin
                            rdata <= 8'h00;
                        end else if (!op_write_reg) begin
                            rdata <= mem[mem_idx];
                        end
                        err       <= !in_range;
                        ready     <= 1'b1;
                        state_reg <= RESP;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                RESP: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Storage is kept out of the reset domain so contents survive rst.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_idx] <= wdata_reg;
        end
    end

endmodule

// File: tb/tb_memory_responder.sv
// Randomized bench for memory_responder: three instances (WAIT 2/1/15) checked
// against an array model of memory contents and last returned data.
module tb_memory_responder;
    localparam int NI = 3;
    localparam int WAITS  [NI] = '{2, 1, 15};
    localparam int DEPTHS [NI] = '{8192, 4096, 8192};

    logic        clk = 1'b0;
    logic        rst_s   [NI];
    logic        rd_s    [NI];
    logic        wr_s    [NI];
    logic [12:0] addr_s  [NI];
    logic [7:0]  wdata_s [NI];
    logic [7:0]  rdata_s [NI];
    logic        ready_s [NI];
    logic        busy_s  [NI];
    logic        err_s   [NI];

    logic [7:0]  mem_model [NI][8192];
    logic [7:0]  last_rd   [NI];
    logic [12:0] pool0 [8] = '{13'h0005, 13'h0010, 13'h0020, 13'h0100,
                               13'h1FFF, 13'h0000, 13'h0ABC, 13'h1234};
    logic [12:0] pool1 [8] = '{13'h0000, 13'h0001, 13'h07FF, 13'h0FFF,
                               13'h1000, 13'h1001, 13'h1FFF, 13'h0FFE};
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        memory_responder #(.WAIT(WAITS[gi]), .DEPTH(DEPTHS[gi])) u_dut (
            .clk      (clk),
            .rst      (rst_s[gi]),
            .MEM_read (rd_s[gi]),
            .MEM_write(wr_s[gi]),
            .addr     (addr_s[gi]),
            .wdata    (wdata_s[gi]),
            .rdata    (rdata_s[gi]),
            .ready    (ready_s[gi]),
            .busy     (busy_s[gi]),
            .err      (err_s[gi])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One complete access, driven from a negedge while the instance is in IDLE.
    task automatic access(input int i, input bit is_wr, input logic [12:0] a,
                          input logic [7:0] d, input bit noise);
        int         k;
        bit         busy_ok;
        bit         in_rng;
        logic [7:0] exp_rd;
        in_rng = (int'(a) < DEPTHS[i]);
        if (!in_rng)    exp_rd = 8'h00;
        else if (is_wr) exp_rd = last_rd[i];
        else            exp_rd = mem_model[i][a];
        rd_s[i] = !is_wr; wr_s[i] = is_wr; addr_s[i] = a; wdata_s[i] = d;
        @(negedge clk);
        rd_s[i] = 1'b0; wr_s[i] = 1'b0;
        if (noise) begin
            wr_s[i]    = 1'b1;
            rd_s[i]    = 1'($urandom_range(0, 1));
            addr_s[i]  = 13'($urandom);
            wdata_s[i] = 8'($urandom);
        end
        k = 0;
        busy_ok = 1'b1;
        while (ready_s[i] !== 1'b1 && k < 40) begin
            if (busy_s[i] !== 1'b1 || err_s[i] !== 1'b0) busy_ok = 1'b0;
            @(negedge clk);
            k++;
            rd_s[i] = 1'b0; wr_s[i] = 1'b0;
        end
        check("latency",     32'(k),          32'(WAITS[i]));
        check("busy_during", 32'(busy_ok),    32'd1);
        check("resp_busy",   32'(busy_s[i]),  32'd1);
        check("resp_err",    32'(err_s[i]),   32'(!in_rng));
        check("rdata",       32'(rdata_s[i]), 32'(exp_rd));
        if (is_wr && in_rng) mem_model[i][a] = d;
        last_rd[i] = exp_rd;
        $display("txn dut%0d %s addr=%h wdata=%h rdata=%h err=%b lat=%0d noise=%0d",
                 i, is_wr ? "WR" : "RD", a, d, rdata_s[i], err_s[i], k, noise);
        @(negedge clk);
        check("post_ready", 32'(ready_s[i]), 32'd0);
        check("post_busy",  32'(busy_s[i]),  32'd0);
        check("post_err",   32'(err_s[i]),   32'd0);
    endtask

    // MEM_read held high: consecutive ready pulses must be WAIT+2 cycles apart.
    task automatic spacing(input int i, input logic [12:0] a);
        int cyc, t_prev, n;
        rd_s[i] = 1'b1; wr_s[i] = 1'b0; addr_s[i] = a;
        cyc = 0; n = 0; t_prev = 0;
        while (n < 3 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (ready_s[i] === 1'b1) begin
                if (n > 0) check("ready_spacing", 32'(cyc - t_prev), 32'(WAITS[i] + 2));
                check("spacing_rdata", 32'(rdata_s[i]), 32'(mem_model[i][a]));
                t_prev = cyc;
                n++;
                if (n == 3) rd_s[i] = 1'b0;
            end
        end
        check("spacing_count", 32'(n), 32'd3);
        $display("txn dut%0d RD-STREAM addr=%h pulses=%0d spacing=%0d", i, a, n, WAITS[i] + 2);
        @(negedge clk);
        last_rd[i] = mem_model[i][a];
    endtask

    task automatic check_zero(input int i, input string tag);
        check({tag, "_rdata"}, 32'(rdata_s[i]), 32'd0);
        check({tag, "_ready"}, 32'(ready_s[i]), 32'd0);
        check({tag, "_busy"},  32'(busy_s[i]),  32'd0);
        check({tag, "_err"},   32'(err_s[i]),   32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NI; i++) begin
            rst_s[i] = 1'b0; rd_s[i] = 1'b0; wr_s[i] = 1'b0;
            addr_s[i] = 13'd0; wdata_s[i] = 8'd0; last_rd[i] = 8'h00;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) check_zero(i, "reset");
        for (int i = 0; i < NI; i++) rst_s[i] = 1'b1;

        // WAIT=2 instance: preload, directed scenarios, then random traffic.
        for (int j = 0; j < 8; j++) access(0, 1'b1, pool0[j], 8'(8'h11 + j * 8'h13), 1'b0);
        access(0, 1'b1, 13'h0005, 8'hA7, 1'b0);
        access(0, 1'b0, 13'h0005, 8'h00, 1'b0);

        rd_s[0] = 1'b1; wr_s[0] = 1'b1; addr_s[0] = 13'h0010; wdata_s[0] = 8'hEE;
        @(negedge clk);
        rd_s[0] = 1'b0; wr_s[0] = 1'b0;
        check("dual_err",   32'(err_s[0]),   32'd1);
        check("dual_busy",  32'(busy_s[0]),  32'd0);
        check("dual_ready", 32'(ready_s[0]), 32'd0);
        $display("txn dut0 RD+WR addr=0010 err=%b", err_s[0]);
        @(negedge clk);
        check("dual_err_clear", 32'(err_s[0]),  32'd0);
        check("dual_busy_idle", 32'(busy_s[0]), 32'd0);
        access(0, 1'b0, 13'h0010, 8'h00, 1'b0);

        access(0, 1'b0, 13'h0100, 8'h00, 1'b1);

        access(0, 1'b0, 13'h0005, 8'h00, 1'b0);
        rd_s[0] = 1'b0; wr_s[0] = 1'b1; addr_s[0] = 13'h0020; wdata_s[0] = 8'h3C;
        @(negedge clk);
        wr_s[0] = 1'b0;
        @(negedge clk);
        rst_s[0] = 1'b0;
        #1;
        check_zero(0, "abort");
        $display("txn dut0 WR addr=0020 wdata=3c aborted by reset");
        last_rd[0] = 8'h00;
        @(negedge clk);
        rst_s[0] = 1'b1;
        access(0, 1'b0, 13'h0020, 8'h00, 1'b0);

        for (int n = 0; n < 40; n++)
            access(0, 1'($urandom_range(0, 1)), pool0[$urandom_range(0, 7)],
                   8'($urandom), $urandom_range(0, 3) == 0);

        // WAIT=1, DEPTH=4096 instance: out-of-range handling and streaming.
        for (int j = 0; j < 8; j++) access(1, 1'b1, pool1[j], 8'(8'h11 + j * 8'h13), 1'b0);
        access(1, 1'b0, 13'h07FF, 8'h00, 1'b0);
        access(1, 1'b0, 13'h1000, 8'h00, 1'b0);
        spacing(1, 13'h07FF);
        for (int n = 0; n < 30; n++)
            access(1, 1'($urandom_range(0, 1)), pool1[$urandom_range(0, 7)],
                   8'($urandom), $urandom_range(0, 3) == 0);
        access(1, 1'b0, 13'h0000, 8'h00, 1'b0);

        // WAIT=15 instance.
        access(2, 1'b1, 13'h0033, 8'h5A, 1'b0);
        spacing(2, 13'h0033);
        access(2, 1'b1, 13'h1FFF, 8'hC3, 1'b1);
        access(2, 1'b0, 13'h1FFF, 8'h00, 1'b0);
        access(2, 1'b0, 13'h0033, 8'h00, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
